uart_param_xcvr: RTL
====================

Name: uart_param_xcvr

Overview:
Parametrised full-duplex UART transceiver, the successor to the fixed 8-bit uart block. Data width, bit period, parity mode and stop-bit count are configurable. The receive path adds a synchroniser, mid-bit sampling, a held valid/ready handshake and framing, parity and overrun flags. The block sits between the on-chip byte producer/consumer and the serial pins; txd may be wired to rxd for loopback.

Parameters:
CLK_DIV, 16, clock cycles per serial bit; minimum 4, must be even.
DATA_BITS, 8, payload bits per frame; range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits transmitted; 1 or 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset.
tx_start  in  1  request to send tx_data; sampled only in TX IDLE.
tx_data  in  DATA_BITS  payload; latched in the cycle tx_start is accepted.
tx_busy  out  1  high from the cycle after acceptance until frame end.
tx_done  out  1  one-cycle pulse in the cycle the last stop bit ends.
txd  out  1  serial output; idles high.
rxd  in  1  serial input, asynchronous to clk.
rx_data  out  DATA_BITS  received payload; valid while rx_valid=1.
rx_valid  out  1  frame available; held until consumed.
rx_ready  in  1  consumer accepts; rx_valid & rx_ready clears rx_valid.
rx_frame_err  out  1  first stop bit sampled low; qualifies rx_data.
rx_parity_err  out  1  parity mismatch; always 0 when PARITY=0.
rx_overrun  out  1  a frame was dropped; sticky until the next consume.

Behaviour:
- Reset (rst=0 at a clock edge): txd=1, tx_busy=0, tx_done=0, rx_valid=0, rx_data=0, all error flags 0. Both FSMs go to IDLE and the synchroniser loads 1. A reset mid-frame aborts the frame immediately; no tx_done pulse.
- Frame format: start bit (0), then DATA_BITS data bits LSB first, then an optional parity bit, then STOP_BITS stop bits (1). Bits per frame = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_start=1 latches tx_data and moves to START. tx_busy=1 and txd=0 from the next cycle.
  - Each state holds its bit for exactly CLK_DIV cycles. The bit counter advances DATA and STOP.
  - PARITY is skipped when PARITY=0. Odd mode: total number of ones in data+parity is odd. Even mode: that total is even.
  - In the final cycle of the last stop bit, tx_done=1. The next cycle is IDLE with tx_busy=0 and txd=1.
  - Total busy time = bits per frame × CLK_DIV cycles.
  - tx_start while busy is ignored and not queued. tx_start held high in IDLE starts a new frame back-to-back.
- RX path: rxd passes through a 2-flop synchroniser (2-cycle latency). The RX FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: a high-to-low transition on the synchronised rxd moves to START.
  - START: wait CLK_DIV/2 cycles. If the line is still low, go to DATA; if high, treat it as a glitch and return to IDLE with no flags.
  - Later bits are sampled every CLK_DIV cycles, at mid-bit.
  - Only the first stop bit is checked. Low sets the frame error; the frame is still delivered.
  - After the stop-bit sample, the FSM returns to IDLE and re-arms on the next falling edge.
- Delivery, in the stop-sample cycle:
  - If rx_valid=0, or rx_valid & rx_ready in the same cycle: load rx_data and both error flags, and set rx_valid=1 on the next cycle. No overrun.
  - Otherwise: discard the new frame, keep the old data and flags, and set rx_overrun=1.
- Consume (rx_valid & rx_ready with no simultaneous delivery): clear rx_valid, rx_frame_err, rx_parity_err and rx_overrun.
- Counters are sized $clog2(CLK_DIV) and $clog2(DATA_BITS+1) and wrap only by explicit reload. No arithmetic overflow is reachable.

Decomposition:
- Shared package uart_pkg holds:
  - the parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the TX/RX state encodings IDLE, START, DATA, PARITY, STOP;
  - a frame-length function of the parameters.
- One sub-module, uart_rx_core, contains the synchroniser, RX FSM and delivery/flag logic. The TX FSM stays inline in uart_param_xcvr.

Test Plan:
All scenarios use CLK_DIV=4 and hold rst=0 for 2 cycles, unless stated otherwise.
1. Loopback (txd→rxd), DATA_BITS=8, PARITY=0, STOP_BITS=1; tx_data=8'hDB, one-cycle tx_start → tx_busy high exactly 40 cycles; one tx_done pulse; txd LSB-first pattern 0,1,1,0,1,1,0,1,1,1; rx_valid=1 with rx_data=8'hDB and no flags.
2. PARITY=2, tx_data=8'h07 → parity bit 1 on txd, frame 44 cycles; loopback rx_parity_err=0. Drive rxd externally with the parity bit inverted → rx_parity_err=1 and rx_data=8'h07.
3. rxd frame with the stop bit driven 0 → rx_frame_err=1 and rx_valid=1. After a one-cycle rx_ready, all flags and rx_valid are 0.
4. Two loopback frames 8'hA5 then 8'h3C with rx_ready=0 → rx_data stays 8'hA5 and rx_overrun=1. Repeat with rx_ready pulsed in the second frame's stop-sample cycle → rx_data=8'h3C and rx_overrun=0.
5. 1-cycle low glitch on rxd (shorter than CLK_DIV/2) → rx_valid stays 0 and the FSM returns to IDLE. tx_start pulsed mid-frame → no second frame and a single tx_done.
6. rst=0 asserted mid-TX and mid-RX → the next cycle shows txd=1, tx_busy=0, rx_valid=0. A new 8'h5A frame after reset is sent and received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encodings, frame length.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

   // Parity modes
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // TX/RX FSM state encodings (shared by both directions)
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Serial bits per frame: start + data + optional parity + stop bits
   function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receive path: 2-flop synchroniser, mid-bit sampling FSM, held result with error flags.
// Latency: result valid the cycle after the first stop-bit sample (~2 sync cycles + CLK_DIV/2 into the stop bit).
// Backpressure: rx_valid held until rx_valid & rx_ready; a frame arriving while held is dropped and flagged as overrun.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

   logic                 sync1;
   logic                 sync2;
   logic                 line_prev;
   logic                 fall;
   logic [2:0]           state;
   logic [CW-1:0]        baud;
   logic [BW-1:0]        bitn;
   logic [DATA_BITS-1:0] shreg;
   logic                 bit_mid;
   logic                 sample_stop;
   logic                 parity_err_new;

   assign fall        = line_prev & ~sync2;
   assign bit_mid     = (baud == BAUD_LAST);
   assign sample_stop = (state == ST_STOP) && bit_mid;

   // Synchronise the asynchronous line and keep one delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         line_prev <= 1'b1;
      end else begin
         sync1     <= rxd;
         sync2     <= sync1;
         line_prev <= sync2;
      end
   end

   // Frame FSM: half-bit wait validates the start bit, then one sample per bit period
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
         baud  <= '0;
         bitn  <= '0;
         shreg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fall) begin
                  state <= ST_START;
                  baud  <= '0;
               end
            end
            ST_START: begin
               if (baud == HALF_LAST) begin
                  baud  <= '0;
                  bitn  <= '0;
                  state <= sync2 ? ST_IDLE : ST_DATA;  // high at mid-start = glitch
               end else begin
                  baud <= baud + CW'(1);
               end
            end
            ST_DATA: begin
               if (bit_mid) begin
                  baud  <= '0;
                  shreg <= {sync2, shreg[DATA_BITS-1:1]};
                  if (bitn == DATA_LAST) begin
                     state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                     bitn <= bitn + BW'(1);
                  end
               end else begin
                  baud <= baud + CW'(1);
               end
            end
            ST_PARITY: begin
               if (bit_mid) begin
                  baud  <= '0;
                  state <= ST_STOP;
               end else begin
                  baud <= baud + CW'(1);
               end
            end
            ST_STOP: begin
               if (bit_mid) begin
                  baud  <= '0;
                  state <= ST_IDLE;
               end else begin
                  baud <= baud + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   generate
      if (PARITY != PAR_NONE) begin : g_par
         logic par_rx;

         // Capture the received parity bit at its mid-bit sample
         always_ff @(posedge clk) begin
            if (!rst) begin
               par_rx <= 1'b0;
            end else if ((state == ST_PARITY) && bit_mid) begin
               par_rx <= sync2;
            end
         end

         // Odd mode expects an odd total of ones over data+parity, even mode an even total
         assign parity_err_new = (PARITY == PAR_ODD) ? ~(^shreg ^ par_rx) : (^shreg ^ par_rx);
      end else begin : g_nopar
         assign parity_err_new = 1'b0;
      end
   endgenerate

   // Deliver on the stop sample unless an unconsumed frame is held; consume clears everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overrun    <= 1'b0;
      end else if (sample_stop) begin
         if (!rx_valid || rx_ready) begin
            rx_data       <= shreg;
            rx_frame_err  <= ~sync2;
            rx_parity_err <= parity_err_new;
            rx_valid      <= 1'b1;
            rx_overrun    <= 1'b0;
         end else begin
            rx_overrun <= 1'b1;
         end
      end else if (rx_valid && rx_ready) begin
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overrun    <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_param_xcvr.sv
// Parametrised full-duplex UART: inline TX FSM plus uart_rx_core receive path.
// Latency: txd starts the cycle after tx_start is accepted; busy for frame_bits*CLK_DIV cycles.
// Backpressure: tx_start ignored while tx_busy (not queued); RX holds one frame, see uart_rx_core.
module uart_param_xcvr
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 txd,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int FB = frame_bits(DATA_BITS, PARITY, STOP_BITS);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   logic [2:0]    tx_state;
   logic [CW-1:0] tx_baud;
   logic [BW-1:0] tx_bit;
   logic [FB-1:0] tx_sh;     // whole frame, LSB goes out first; ones shift in behind
   logic [FB-1:0] tx_frame;
   logic          bit_end;

   generate
      if (PARITY != PAR_NONE) begin : g_par
         logic par_bit;
         assign par_bit  = (PARITY == PAR_EVEN) ? ^tx_data : ~^tx_data;
         assign tx_frame = {{STOP_BITS{1'b1}}, par_bit, tx_data, 1'b0};
      end else begin : g_nopar
         assign tx_frame = {{STOP_BITS{1'b1}}, tx_data, 1'b0};
      end
   endgenerate

   assign bit_end = (tx_baud == BAUD_LAST);
   assign tx_busy = (tx_state != ST_IDLE);
   assign tx_done = (tx_state == ST_STOP) && bit_end && (tx_bit == STOP_LAST);
   assign txd     = tx_sh[0];

   // TX FSM: each state holds its bit for CLK_DIV cycles; the shift register supplies the line value
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state <= ST_IDLE;
         tx_baud  <= '0;
         tx_bit   <= '0;
         tx_sh    <= '1;
      end else begin
         case (tx_state)
            ST_IDLE: begin
               if (tx_start) begin
                  tx_sh    <= tx_frame;
                  tx_baud  <= '0;
                  tx_bit   <= '0;
                  tx_state <= ST_START;
               end
            end
            default: begin
               if (!bit_end) begin
                  tx_baud <= tx_baud + CW'(1);
               end else begin
                  tx_baud <= '0;
                  tx_sh   <= {1'b1, tx_sh[FB-1:1]};
                  case (tx_state)
                     ST_START: begin
                        tx_state <= ST_DATA;
                        tx_bit   <= '0;
                     end
                     ST_DATA: begin
                        if (tx_bit == DATA_LAST) begin
                           tx_bit   <= '0;
                           tx_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                           tx_bit <= tx_bit + BW'(1);
                        end
                     end
                     ST_PARITY: begin
                        tx_state <= ST_STOP;
                        tx_bit   <= '0;
                     end
                     ST_STOP: begin
                        if (tx_bit == STOP_LAST) begin
                           tx_state <= ST_IDLE;
                        end else begin
                           tx_bit <= tx_bit + BW'(1);
                        end
                     end
                     default: tx_state <= ST_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   uart_rx_core #(
      .CLK_DIV   (CLK_DIV),
      .DATA_BITS (DATA_BITS),
      .PARITY    (PARITY)
   ) u_rx (
      .clk           (clk),
      .rst           (rst),
      .rxd           (rxd),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err),
      .rx_overrun    (rx_overrun)
   );

endmodule
